multicore_sched: RTL and testbench

Parametrised release-and-output controller for a bank of `rede` network cores. It brings the cores out of reset one at a time with a programmable stagger. It arbitrates their output words onto a single registered stream with a valid/ready handshake, and acknowledges each core when its word is taken. It sits between the core instances and the downstream consumer, and replaces the fixed 21-core, fixed-priority arrangement.

---
 rtl/multicore_pkg.sv | 22 ++
 rtl/multicore_arb.sv | 38 +++
 rtl/multicore_sched.sv | 166 ++++++++++++++++
 tb/tb_multicore_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// multicore_pkg: shared types, default parameters and width helper for the
// multicore_sched release/arbitration controller.
package multicore_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int N_CORES_DEF = 21;
  localparam int DATA_W_DEF  = 31;
  localparam int EN_W_DEF    = 4;
  localparam int STAGGER_DEF = 24;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cw(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/multicore_arb.sv
// multicore_arb: combinational request-to-one-hot grant.
// Default build is fixed priority (lowest index wins). Defining
// MULTICORE_RR_EN selects round robin starting after the last grant.
module multicore_arb import multicore_pkg::*; #(
  parameter int N_CORES = N_CORES_DEF,
  parameter int PTR_W   = cw(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
`ifdef MULTICORE_RR_EN
  input  logic [PTR_W-1:0]   last,
`endif
  output logic [N_CORES-1:0] grant
);

`ifdef MULTICORE_RR_EN
  logic [PTR_W:0]       sh;
  logic [2*N_CORES-1:0] req_dbl;
  logic [N_CORES-1:0]   rot;
  logic [N_CORES-1:0]   rot_grant;
  logic [2*N_CORES-1:0] grant_dbl;

  // Rotate so last+1 sits at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    sh        = {1'b0, last} + (PTR_W + 1)'(1);
    req_dbl   = {req, req} >> sh;
    rot       = req_dbl[N_CORES-1:0];
    rot_grant = rot & (~rot + N_CORES'(1));
    grant_dbl = {rot_grant, rot_grant} << sh;
    grant     = grant_dbl[2*N_CORES-1:N_CORES];
  end
`else
  // Isolate the lowest set request bit.
  always_comb begin
    grant = req & (~req + N_CORES'(1));
  end
`endif

endmodule

// File: rtl/multicore_sched.sv
// multicore_sched: staggered reset release for a bank of cores plus a
// registered valid/ready output stage fed by a one-hot arbiter.
// Optional feature macro: MULTICORE_RR_EN (round-robin arbitration).
module multicore_sched import multicore_pkg::*; #(
  parameter int N_CORES = N_CORES_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int EN_W    = EN_W_DEF,
  parameter int STAGGER = STAGGER_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [N_CORES-1:0]            core_rst,
  input  logic [N_CORES*DATA_W-1:0]     core_io_out,
  input  logic [N_CORES*EN_W-1:0]       core_out_en,
  output logic [N_CORES-1:0]            core_ack,
  output logic signed [DATA_W-1:0]      io_out,
  output logic [EN_W-1:0]               out_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          all_up,
  output logic [cw(N_CORES+1)-1:0]      active_cnt
);

  localparam int SLOT_W = cw(N_CORES);
  localparam int CNT_W  = cw(STAGGER);
  localparam int ACT_W  = cw(N_CORES + 1);

  state_t              state, state_nxt;
  logic [SLOT_W-1:0]   slot, slot_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;

  logic [N_CORES-1:0]  req;
  logic [N_CORES-1:0]  grant;
  logic                load;
  logic signed [DATA_W-1:0] win_data;
  logic [EN_W-1:0]     win_en;

  // Release FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      slot  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Release FSM next state: walk slots, STAGGER cycles each, then RUN forever.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RELEASE;
          slot_nxt  = '0;
          cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        if (cnt == CNT_W'(STAGGER - 1)) begin
          cnt_nxt = '0;
          if (slot == SLOT_W'(N_CORES - 1)) state_nxt = RUN;
          else                              slot_nxt  = slot + SLOT_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Core reset release, live-core count and all-up flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_rst   <= '1;
      active_cnt <= '0;
      all_up     <= 1'b0;
    end else begin
      if (state == RELEASE && cnt == '0) begin
        core_rst[slot] <= 1'b0;
        active_cnt     <= active_cnt + ACT_W'(1);
      end
      if (state == RUN) all_up <= 1'b1;
    end
  end

  // Requests: enabled, out of reset, and not acknowledged in this very cycle.
  always_comb begin
    req = '0;
    for (int k = 0; k < N_CORES; k++) begin
      req[k] = (|core_out_en[k*EN_W +: EN_W]) && !core_rst[k] && !core_ack[k];
    end
  end

`ifdef MULTICORE_RR_EN
  logic [SLOT_W-1:0] last_grant;
  logic [SLOT_W-1:0] win_idx;

  multicore_arb #(.N_CORES(N_CORES), .PTR_W(SLOT_W)) u_arb (
    .req   (req),
    .last  (last_grant),
    .grant (grant)
  );

  // Round-robin pointer advances only when a word is actually loaded.
  always_ff @(posedge clk) begin
    if (!rst)                  last_grant <= '0;
    else if (load && (|req))   last_grant <= win_idx;
  end
`else
  multicore_arb #(.N_CORES(N_CORES), .PTR_W(SLOT_W)) u_arb (
    .req   (req),
    .grant (grant)
  );
`endif

  // Winner mux driven by the one-hot grant.
  always_comb begin
    win_data = '0;
    win_en   = '0;
`ifdef MULTICORE_RR_EN
    win_idx  = '0;
`endif
    for (int k = 0; k < N_CORES; k++) begin
      if (grant[k]) begin
        win_data = core_io_out[k*DATA_W +: DATA_W];
        win_en   = core_out_en[k*EN_W +: EN_W];
`ifdef MULTICORE_RR_EN
        win_idx  = SLOT_W'(k);
`endif
      end
    end
  end

  assign load = !out_valid || out_ready;

  // Output register: load a winner when the slot is free or being drained.
  always_ff @(posedge clk) begin
    if (!rst) begin
      io_out    <= '0;
      out_en    <= '0;
      out_valid <= 1'b0;
      core_ack  <= '0;
    end else begin
      core_ack <= '0;
      if (load) begin
        if (|req) begin
          io_out    <= win_data;
          out_en    <= win_en;
          out_valid <= 1'b1;
          core_ack  <= grant;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicore_sched.sv
// tb_multicore_sched: scoreboard bench for multicore_sched with 4 cores,
// 8-bit data, 4-bit enables and a 3-cycle stagger.
module tb_multicore_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int EW = 4;
  localparam int ST = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    logic [N-1:0]  a;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N-1:0]      core_rst;
  logic [N*DW-1:0]   core_io_out;
  logic [N*EW-1:0]   core_out_en;
  logic [N-1:0]      core_ack;
  logic [DW-1:0]     io_out;
  logic [EW-1:0]     out_en;
  logic              out_valid;
  logic              out_ready;
  logic              all_up;
  logic [2:0]        active_cnt;

  logic [DW-1:0] d_arr [N];
  logic [EW-1:0] e_arr [N];
  int            post_seq [N];
  int            done_seq [N];

  exp_t sbq[$];
  int   compared = 0;
  int   mismatched = 0;

  multicore_sched #(.N_CORES(N), .DATA_W(DW), .EN_W(EW), .STAGGER(ST)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .core_rst    (core_rst),
    .core_io_out (core_io_out),
    .core_out_en (core_out_en),
    .core_ack    (core_ack),
    .io_out      (io_out),
    .out_en      (out_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .all_up      (all_up),
    .active_cnt  (active_cnt)
  );

  always #5 clk = ~clk;

  // Core model: a posted word is offered until its ack is seen.
  always_comb begin
    core_io_out = '0;
    core_out_en = '0;
    for (int k = 0; k < N; k++) begin
      core_io_out[k*DW +: DW] = d_arr[k];
      core_out_en[k*EW +: EW] = (post_seq[k] != done_seq[k]) ? e_arr[k] : '0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int k, input logic [DW-1:0] d, input logic [EW-1:0] e);
    exp_t x;
    d_arr[k] = d;
    e_arr[k] = e;
    post_seq[k] = post_seq[k] + 1;
    x.d = d;
    x.e = e;
    x.a = N'(1) << k;
    sbq.push_back(x);
  endtask

  // Monitor: every ack pulse marks a freshly loaded word.
  always @(negedge clk) begin
    if ((|core_ack) === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 64'(core_ack), 64'd0);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("ack",       64'(core_ack),  64'(x.a));
        chk("io_out",    64'(io_out),    64'(x.d));
        chk("out_en",    64'(out_en),    64'(x.e));
        chk("out_valid", 64'(out_valid), 64'd1);
      end
      for (int k = 0; k < N; k++) begin
        if (core_ack[k]) done_seq[k] = post_seq[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_rst;
    int           exp_cnt;
    for (int k = 0; k < N; k++) begin
      d_arr[k] = '0;
      e_arr[k] = '0;
      post_seq[k] = 0;
      done_seq[k] = 0;
    end
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    chk("rst_core_rst",   64'(core_rst),   64'hF);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_active_cnt", 64'(active_cnt), 64'd0);
    chk("rst_all_up",     64'(all_up),     64'd0);
    chk("rst_core_ack",   64'(core_ack),   64'd0);
    chk("rst_io_out",     64'(io_out),     64'd0);
    rst = 1'b1;
    step();

    // Staggered release; core 3 requests while still held in reset.
    post(3, 8'h55, 4'h1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step();
      exp_rst = '1;
      exp_cnt = 0;
      for (int k = 0; k < N; k++) begin
        if (j >= 1 + k*ST) begin
          exp_rst[k] = 1'b0;
          exp_cnt++;
        end
      end
      chk($sformatf("rel_core_rst_%0d", j),  64'(core_rst),   64'(exp_rst));
      chk($sformatf("rel_active_%0d", j),    64'(active_cnt), 64'(exp_cnt));
      chk($sformatf("rel_all_up_%0d", j),    64'(all_up),     64'(j >= 1 + N*ST));
      chk($sformatf("rel_valid_%0d", j),     64'(out_valid),  64'(j == 11));
    end

    // Fixed priority: cores 1 and 3 together.
    post(1, 8'h11, 4'h2);
    post(3, 8'h33, 4'h4);
    step();
    chk("fp_first", 64'(io_out), 64'h11);
    step();
    chk("fp_second", 64'(io_out), 64'h33);
    step();
    chk("fp_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: -7 from core 2 held while core 0 waits.
    out_ready = 1'b0;
    post(2, 8'hF9, 4'h3);
    step();
    chk("bp_load_io", 64'(io_out), 64'hF9);
    post(0, 8'h0A, 4'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold_io_%0d", i),    64'(io_out),    64'hF9);
      chk($sformatf("bp_hold_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold_ack_%0d", i),   64'(core_ack),  64'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_io", 64'(io_out), 64'h0A);
    step();
    chk("bp_drain_valid", 64'(out_valid), 64'd0);

    // Mid-operation reset during slot 2 with a word held.
    rst = 1'b0;
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    post(0, 8'h77, 4'h2);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    chk("mid_pending_valid", 64'(out_valid),  64'd1);
    chk("mid_active_cnt",    64'(active_cnt), 64'd3);
    rst = 1'b0;
    step();
    chk("mid_core_rst",   64'(core_rst),   64'hF);
    chk("mid_out_valid",  64'(out_valid),  64'd0);
    chk("mid_active_cnt0",64'(active_cnt), 64'd0);
    chk("mid_all_up",     64'(all_up),     64'd0);
    chk("mid_io_out",     64'(io_out),     64'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("restart_core_rst", 64'(core_rst),   64'hE);
    chk("restart_active",   64'(active_cnt), 64'd1);
    step();
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
